// File: rtl/btb_pkg.sv
// Shared types, field positions and PC hashing for the BTB write-side controller.
package btb_pkg;
    localparam int SETS    = 128;
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = 10;
    localparam int ENTRY_W = 45;

    localparam int VALID_BIT = 44;
    localparam int TAG_MSB   = 43;
    localparam int TAG_LSB   = 34;
    localparam int TGT_MSB   = 33;
    localparam int TGT_LSB   = 2;
    localparam int CTR_MSB   = 1;
    localparam int CTR_LSB   = 0;

    localparam logic [1:0] CTR_INIT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FLUSH  = 2'd3
    } btb_state_e;

    function automatic logic [IDX_W-1:0] btb_index(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] btb_tag(input logic [31:0] pc);
        return pc[18:9] ^ pc[28:19];
    endfunction

    function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
        if (ctr == 2'b11) begin
            return 2'b11;
        end else begin
            return ctr + 2'b01;
        end
    endfunction
endpackage

// File: rtl/btb_update_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer moves past whichever port was granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr_r;

    // Favour the pointed-to port, fall back to the other one.
    always_comb begin
        if (ptr_r == 1'b0) begin
            gnt = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
        end else begin
            gnt = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
        end
    end

    // After a grant to port 0 prefer port 1, and vice versa.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_r <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr_r <= gnt[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write-side controller: arbitrates two update ports, does read-compare-write
// with per-set LRU and confidence counters, and sequences the full-array clear.
module btb_update_ctrl
    import btb_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               upd0_valid,
    output logic               upd0_ready,
    input  logic [31:0]        upd0_pc,
    input  logic [31:0]        upd0_target,
    input  logic               upd0_taken,
    input  logic               upd1_valid,
    output logic               upd1_ready,
    input  logic [31:0]        upd1_pc,
    input  logic [31:0]        upd1_target,
    input  logic               upd1_taken,
    input  logic               flush_req,
    output logic               busy,
    output logic [IDX_W-1:0]   rd_index,
    input  logic [ENTRY_W-1:0] rd_way0,
    input  logic [ENTRY_W-1:0] rd_way1,
    output logic [1:0]         wr_en,
    output logic [IDX_W-1:0]   wr_index,
    output logic [ENTRY_W-1:0] wr_data
);
    btb_state_e         state_r;
    logic [IDX_W:0]     flush_cnt_r;
    logic               flush_pend_r;
    logic [SETS-1:0]    lru_r;
    logic [31:0]        req_pc_r;
    logic [31:0]        req_tgt_r;
    logic               req_taken_r;
    logic               lru_wr_val_r;
    logic [1:0]         wr_en_r;
    logic [IDX_W-1:0]   wr_index_r;
    logic [ENTRY_W-1:0] wr_data_r;
    logic               busy_r;

    logic               can_grant_s;
    logic [1:0]         arb_req_s;
    logic [1:0]         gnt_s;
    logic [31:0]        gnt_pc_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic               hit0_s;
    logic               hit1_s;
    logic [ENTRY_W-1:0] hit_ent_s;
    logic               lk_we_s;
    logic               lk_way_s;
    logic               lk_lru_s;
    logic [ENTRY_W-1:0] lk_data_s;

    assign req_idx_s = btb_index(req_pc_r);
    assign req_tag_s = btb_tag(req_pc_r);
    assign gnt_pc_s  = gnt_s[1] ? upd1_pc : upd0_pc;
    assign arb_req_s = can_grant_s ? {upd1_valid, upd0_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .req     (arb_req_s),
        .advance (gnt_s != 2'b00),
        .gnt     (gnt_s)
    );

    // A pending or fresh flush blocks new grants in IDLE.
    always_comb begin
        if (resetn && (state_r == ST_IDLE) && !flush_req && !flush_pend_r) begin
            can_grant_s = 1'b1;
        end else begin
            can_grant_s = 1'b0;
        end
    end

    // Read address follows the request being granted this cycle so data lands in LOOKUP.
    always_comb begin
        if (!resetn) begin
            rd_index = {IDX_W{1'b0}};
        end else if (gnt_s != 2'b00) begin
            rd_index = btb_index(gnt_pc_s);
        end else begin
            rd_index = req_idx_s;
        end
    end

    // Hit detection, victim choice and the entry/LRU value to commit.
    always_comb begin
        hit0_s    = rd_way0[VALID_BIT] && (rd_way0[TAG_MSB:TAG_LSB] == req_tag_s);
        hit1_s    = rd_way1[VALID_BIT] && (rd_way1[TAG_MSB:TAG_LSB] == req_tag_s);
        hit_ent_s = hit0_s ? rd_way0 : rd_way1;
        lk_we_s   = 1'b0;
        lk_way_s  = 1'b0;
        lk_lru_s  = 1'b0;
        lk_data_s = {ENTRY_W{1'b0}};
        if (req_taken_r) begin
            lk_we_s = 1'b1;
            if (hit0_s || hit1_s) begin
                lk_way_s  = ~hit0_s;
                lk_data_s = {1'b1, req_tag_s, req_tgt_r, ctr_inc(hit_ent_s[CTR_MSB:CTR_LSB])};
            end else begin
                if (!rd_way0[VALID_BIT]) begin
                    lk_way_s = 1'b0;
                end else if (!rd_way1[VALID_BIT]) begin
                    lk_way_s = 1'b1;
                end else begin
                    lk_way_s = lru_r[req_idx_s];
                end
                lk_data_s = {1'b1, req_tag_s, req_tgt_r, CTR_INIT};
            end
            lk_lru_s = ~lk_way_s;
        end else if (hit0_s || hit1_s) begin
            lk_we_s   = 1'b1;
            lk_way_s  = ~hit0_s;
            lk_data_s = hit_ent_s;
            if (hit_ent_s[CTR_MSB:CTR_LSB] == 2'b00) begin
                // Invalidated way becomes the preferred victim.
                lk_data_s[VALID_BIT] = 1'b0;
                lk_lru_s             = lk_way_s;
            end else begin
                lk_data_s[CTR_MSB:CTR_LSB] = hit_ent_s[CTR_MSB:CTR_LSB] - 2'b01;
                lk_lru_s                   = ~lk_way_s;
            end
        end else begin
            lk_we_s = 1'b0;
        end
    end

    // Main FSM with registered write-port and busy outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_FLUSH;
            flush_cnt_r  <= {(IDX_W+1){1'b0}};
            flush_pend_r <= 1'b0;
            lru_r        <= {SETS{1'b0}};
            req_pc_r     <= 32'h0000_0000;
            req_tgt_r    <= 32'h0000_0000;
            req_taken_r  <= 1'b0;
            lru_wr_val_r <= 1'b0;
            wr_en_r      <= 2'b00;
            wr_index_r   <= {IDX_W{1'b0}};
            wr_data_r    <= {ENTRY_W{1'b0}};
            busy_r       <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush_req || flush_pend_r) begin
                        state_r      <= ST_FLUSH;
                        flush_pend_r <= 1'b0;
                        flush_cnt_r  <= (IDX_W+1)'(1);
                        wr_en_r      <= 2'b11;
                        wr_index_r   <= {IDX_W{1'b0}};
                        wr_data_r    <= {ENTRY_W{1'b0}};
                        busy_r       <= 1'b1;
                    end else if (gnt_s != 2'b00) begin
                        state_r     <= ST_LOOKUP;
                        req_pc_r    <= gnt_pc_s;
                        req_tgt_r   <= gnt_s[1] ? upd1_target : upd0_target;
                        req_taken_r <= gnt_s[1] ? upd1_taken : upd0_taken;
                        wr_en_r     <= 2'b00;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r <= ST_IDLE;
                        wr_en_r <= 2'b00;
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOOKUP: begin
                    flush_pend_r <= flush_pend_r | flush_req;
                    wr_en_r      <= lk_we_s ? (lk_way_s ? 2'b10 : 2'b01) : 2'b00;
                    wr_index_r   <= req_idx_s;
                    wr_data_r    <= lk_data_s;
                    lru_wr_val_r <= lk_lru_s;
                    state_r      <= lk_we_s ? ST_WRITE : ST_IDLE;
                end
                ST_WRITE: begin
                    flush_pend_r      <= flush_pend_r | flush_req;
                    lru_r[req_idx_s]  <= lru_wr_val_r;
                    wr_en_r           <= 2'b00;
                    state_r           <= ST_IDLE;
                end
                ST_FLUSH: begin
                    flush_pend_r <= 1'b0;
                    if (flush_cnt_r == (IDX_W+1)'(SETS)) begin
                        state_r <= ST_IDLE;
                        wr_en_r <= 2'b00;
                        busy_r  <= 1'b0;
                    end else begin
                        wr_en_r     <= 2'b11;
                        wr_index_r  <= flush_cnt_r[IDX_W-1:0];
                        wr_data_r   <= {ENTRY_W{1'b0}};
                        flush_cnt_r <= flush_cnt_r + (IDX_W+1)'(1);
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_FLUSH;
                    flush_cnt_r <= {(IDX_W+1){1'b0}};
                    wr_en_r     <= 2'b00;
                    busy_r      <= 1'b1;
                end
            endcase
        end
    end

    assign upd0_ready = gnt_s[0];
    assign upd1_ready = gnt_s[1];
    assign busy       = busy_r;
    assign wr_en      = wr_en_r;
    assign wr_index   = wr_index_r;
    assign wr_data    = wr_data_r;
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Randomized bench for btb_update_ctrl: a BTB array model answers reads, and a
// set-level reference model predicts every grant, write and flush cycle.
module tb_btb_update_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        upd0_valid, upd1_valid, upd0_taken, upd1_taken;
    logic        upd0_ready, upd1_ready;
    logic [31:0] upd0_pc, upd0_target, upd1_pc, upd1_target;
    logic        flush_req;
    logic        busy;
    logic [6:0]  rd_index, wr_index;
    logic [44:0] rd_way0, rd_way1, wr_data;
    logic [1:0]  wr_en;

    btb_update_ctrl dut (
        .clk(clk), .resetn(resetn),
        .upd0_valid(upd0_valid), .upd0_ready(upd0_ready), .upd0_pc(upd0_pc),
        .upd0_target(upd0_target), .upd0_taken(upd0_taken),
        .upd1_valid(upd1_valid), .upd1_ready(upd1_ready), .upd1_pc(upd1_pc),
        .upd1_target(upd1_target), .upd1_taken(upd1_taken),
        .flush_req(flush_req), .busy(busy), .rd_index(rd_index),
        .rd_way0(rd_way0), .rd_way1(rd_way1),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // BTB storage: synchronous read, per-way write; starts full of valid garbage.
    logic [44:0] mem0 [128];
    logic [44:0] mem1 [128];
    logic        scramble = 1'b1;
    always @(posedge clk) begin
        rd_way0 <= mem0[rd_index];
        rd_way1 <= mem1[rd_index];
        if (scramble) begin
            for (int i = 0; i < 128; i++) begin
                mem0[i] <= {1'b1, 12'($urandom), 32'($urandom)};
                mem1[i] <= {1'b1, 12'($urandom), 32'($urandom)};
            end
        end else begin
            if (wr_en[0]) mem0[wr_index] <= wr_data;
            if (wr_en[1]) mem1[wr_index] <= wr_data;
        end
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle)", tag, act, exp);
        end
    endtask

    // Reference model state
    bit          m_v   [2][128];
    logic [9:0]  m_tag [2][128];
    logic [31:0] m_tgt [2][128];
    int          m_ctr [2][128];
    bit          m_lru [128];

    int cyc, free_at, fs, pref, exp_wr_cyc;
    bit fpend;
    logic [1:0]  exp_en;
    logic [6:0]  exp_idx;
    logic [44:0] exp_data;

    bit          dv [2];
    logic [31:0] dpc [2];
    logic [31:0] dtg [2];
    bit          dtk [2];
    bit          dflush;

    function automatic logic [44:0] ent(input int w, input int s);
        return {m_v[w][s], m_tag[w][s], m_tgt[w][s], 2'(m_ctr[w][s])};
    endfunction

    task automatic model_clear();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 128; s++) begin
                m_v[w][s] = 1'b0; m_tag[w][s] = 10'd0; m_tgt[w][s] = 32'd0; m_ctr[w][s] = 0;
            end
    endtask

    task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                                output bit we, output int w, output int s);
        int tg, hw;
        s  = int'((pc >> 2) % 128);
        tg = int'(((pc >> 9) ^ (pc >> 19)) & 32'h3ff);
        hw = -1;
        for (int k = 1; k >= 0; k--)
            if (m_v[k][s] && int'(m_tag[k][s]) == tg) hw = k;
        we = 1'b1;
        w  = 0;
        if (tk) begin
            if (hw >= 0) begin
                w = hw;
                m_ctr[w][s] = (m_ctr[w][s] < 3) ? m_ctr[w][s] + 1 : 3;
            end else begin
                w = !m_v[0][s] ? 0 : (!m_v[1][s] ? 1 : int'(m_lru[s]));
                m_ctr[w][s] = 2;
            end
            m_v[w][s] = 1'b1; m_tag[w][s] = 10'(tg); m_tgt[w][s] = tgt;
            m_lru[s] = (w == 0);
        end else if (hw >= 0) begin
            w = hw;
            if (m_ctr[w][s] == 0) begin
                m_v[w][s] = 1'b0;
                m_lru[s]  = (w == 1);
            end else begin
                m_ctr[w][s] = m_ctr[w][s] - 1;
                m_lru[s]    = (w == 0);
            end
        end else begin
            we = 1'b0;
        end
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, predict grant.
    task automatic step();
        bit in_flush, we;
        int g, w, s;
        @(negedge clk);
        cyc++;
        in_flush = (cyc > fs) && (cyc <= fs + 128);
        if (in_flush) begin
            check_val("flush_busy", 64'(busy), 64'd1);
            check_val("flush_en", 64'(wr_en), 64'd3);
            check_val("flush_idx", 64'(wr_index), 64'(cyc - fs - 1));
            check_val("flush_data", 64'(wr_data), 64'd0);
        end else begin
            check_val("busy", 64'(busy), 64'd0);
            if (cyc == exp_wr_cyc) begin
                check_val("wr_en", 64'(wr_en), 64'(exp_en));
                check_val("wr_index", 64'(wr_index), 64'(exp_idx));
                check_val("wr_data", 64'(wr_data), 64'(exp_data));
            end else begin
                check_val("wr_en_idle", 64'(wr_en), 64'd0);
            end
        end
        upd0_valid = dv[0]; upd0_pc = dpc[0]; upd0_target = dtg[0]; upd0_taken = dtk[0];
        upd1_valid = dv[1]; upd1_pc = dpc[1]; upd1_target = dtg[1]; upd1_taken = dtk[1];
        flush_req  = dflush;
        #1;
        g = -1;
        if (cyc >= free_at) begin
            if (fpend || dflush) begin
                fs = cyc; free_at = cyc + 129; fpend = 1'b0;
                model_clear();
            end else if (dv[0] || dv[1]) begin
                g = dv[pref] ? pref : 1 - pref;
            end
        end else if (dflush && !in_flush) begin
            fpend = 1'b1;
        end
        check_val("ready0", 64'(upd0_ready), 64'(g == 0));
        check_val("ready1", 64'(upd1_ready), 64'(g == 1));
        if (g >= 0) begin
            model_update(dpc[g], dtg[g], dtk[g], we, w, s);
            check_val("rd_index", 64'(rd_index), 64'(s));
            if (we) begin
                exp_wr_cyc = cyc + 2;
                exp_en     = (w == 0) ? 2'b01 : 2'b10;
                exp_idx    = 7'(s);
                exp_data   = ent(w, s);
                free_at    = cyc + 3;
            end else begin
                free_at = cyc + 2;
            end
            pref  = 1 - g;
            dv[g] = 1'b0;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic post(input int p, input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
        dv[p] = 1'b1; dpc[p] = pc; dtg[p] = tgt; dtk[p] = tk;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; flush_req = 1'b0;
        upd0_valid = 1'b1; upd0_pc = 32'h0000_0104; upd0_target = 32'h0; upd0_taken = 1'b1;
        upd1_valid = 1'b1; upd1_pc = 32'h0000_0204; upd1_target = 32'h0; upd1_taken = 1'b1;
        for (int p = 0; p < 2; p++) begin dv[p] = 1'b0; dpc[p] = 32'h0; dtg[p] = 32'h0; dtk[p] = 1'b0; end
        dflush = 1'b0;
        @(negedge clk);
        scramble = 1'b0;
        #1;
        check_val("rst_wr_en", 64'(wr_en), 64'd0);
        check_val("rst_ready0", 64'(upd0_ready), 64'd0);
        check_val("rst_ready1", 64'(upd1_ready), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd1);
        check_val("rst_rd_index", 64'(rd_index), 64'd0);
        resetn = 1'b1;
        upd0_valid = 1'b0; upd1_valid = 1'b0;
        cyc = 0; fs = 0; free_at = 129; pref = 0; fpend = 1'b0; exp_wr_cyc = -1;
        model_clear();
        for (int s = 0; s < 128; s++) m_lru[s] = 1'b0;

        // Power-up clear, then both ports at once (port 0 first)
        steps(129);
        post(0, 32'h0000_0010, 32'h1111_0000, 1'b1);
        post(1, 32'h0000_0024, 32'h2222_0000, 1'b1);
        steps(8);
        // Empty set, taken
        post(0, 32'h0040_0104, 32'h0040_2000, 1'b1);
        steps(4);
        // Fill both ways of set 0x20 then miss: LRU picks way 0
        for (int t = 1; t <= 3; t++) begin
            post(t % 2, (32'(t) << 9) | (32'h20 << 2), 32'h3000_0000 + 32'(t), 1'b1);
            steps(4);
        end
        // Counter walk-down: taken, then four not-taken
        post(0, 32'h0001_0a08, 32'h4444_4444, 1'b1);
        steps(4);
        for (int t = 0; t < 4; t++) begin
            post(t % 2, 32'h0001_0a08, 32'h5555_5555, 1'b0);
            steps(4);
        end
        // Flush pulse during LOOKUP with a waiting requester
        post(0, 32'h0000_0300, 32'h6666_0000, 1'b1);
        step();
        dflush = 1'b1;
        post(0, 32'h0000_0304, 32'h7777_0000, 1'b1);
        step();
        dflush = 1'b0;
        steps(134);
        // Random traffic with a narrow set/tag pool to force hits and evictions
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++)
                if (!dv[p] && $urandom_range(0, 99) < 40)
                    post(p, {3'b000, 10'($urandom_range(0, 1)), 10'($urandom_range(0, 3)),
                             7'($urandom_range(0, 5)), 2'($urandom_range(0, 3))},
                         $urandom, $urandom_range(0, 99) < 65);
            step();
        end
        dv[0] = 1'b0; dv[1] = 1'b0;
        steps(6);
        for (int s = 0; s < 128; s++) begin
            check_val("mem_way0", 64'(mem0[s]), 64'(ent(0, s)));
            check_val("mem_way1", 64'(mem1[s]), 64'(ent(1, s)));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
